// File: rtl/canny_mul_share_arb.sv
// Round-robin scheduler that shares one pipelined signed multiplier among NUM_REQ requesters.
// Each in-flight product carries an id tag that travels in lock-step with the multiplier pipe.
module canny_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIN_W   = 11,
    parameter int DOUT_W  = 22,
    parameter int MUL_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DIN_W-1:0]   req_a,
    input  logic [NUM_REQ*DIN_W-1:0]   req_b,
    output logic                       mul_ce,
    output logic [DIN_W-1:0]           mul_din0,
    output logic [DIN_W-1:0]           mul_din1,
    input  logic [DOUT_W-1:0]          mul_dout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DOUT_W-1:0]          res_data,
    output logic [ID_W-1:0]            res_id,
    output logic                       busy
);

    logic [MUL_LAT-1:0]           r_vld;
    logic [MUL_LAT-1:0][ID_W-1:0] r_id;
    logic [ID_W-1:0]              r_ptr;

    logic                         w_ce;
    logic                         w_found;
    logic                         w_issue;
    logic [ID_W-1:0]              w_idx;
    logic [ID_W-1:0]              w_grant_id;
    logic [NUM_REQ-1:0]           w_grant;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // A result held by downstream freezes the tag pipe and the multiplier together.
    assign w_ce = ~(r_vld[MUL_LAT-1] & ~res_ready);

    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = rr_idx(r_ptr, k);
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    // Gating with reset keeps the combinational grant path at its reset value too.
    assign w_issue   = w_ce & w_found & reset;
    assign w_grant   = w_issue ? (NUM_REQ'(1) << w_grant_id) : '0;
    assign req_ready = w_grant;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                mul_din0 = req_a[i*DIN_W +: DIN_W];
                mul_din1 = req_b[i*DIN_W +: DIN_W];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every stage shifts from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_ce) begin
            r_vld <= {r_vld[MUL_LAT-2:0], w_issue};
            r_id  <= {r_id[MUL_LAT-2:0], (w_issue ? w_grant_id : ID_W'(0))};
            if (w_issue) begin
                r_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
            end
        end
    end

    assign mul_ce    = w_ce;
    assign res_valid = r_vld[MUL_LAT-1];
    assign res_id    = r_id[MUL_LAT-1];
    assign res_data  = mul_dout;
    assign busy      = |r_vld;

endmodule
